// File: rtl/task_frame_reorder.sv
// ---------------------------------------------------------------------------
// task_frame_reorder
//
// Collects one framed input burst (i_first..i_last) into a local buffer. It
// then replays the burst forward or reversed. In the sum modes it appends a
// trailer word that holds the modulo-2^TASK_OUTPUT_WIDTH sum of the frame.
// Any input word that cannot be accepted is reported on o_drop.
//
// Ports
//   i_clk    : clock
//   i_rst    : asynchronous, active-high reset
//   i_valid  : input word valid
//   i_first  : first word of frame (qualified by i_valid)
//   i_last   : last word of frame (qualified by i_valid)
//   i_data   : input word, TASK_INPUT_WIDTH bits
//   i_mode   : replay mode, latched on an accepted first word
//              0 forward, 1 reverse, 2 forward+sum, 3 reverse+sum
//   o_valid  : output word valid
//   o_last   : final output word of the frame
//   o_data   : output word, TASK_OUTPUT_WIDTH bits (holds when o_valid=0)
//   o_busy   : high while a frame is being filled or replayed
//   o_drop   : one-cycle pulse per discarded input word or aborted frame
// ---------------------------------------------------------------------------
module task_frame_reorder #(
    parameter int TASK_INPUT_WIDTH  = 16,
    parameter int TASK_OUTPUT_WIDTH = 16,
    parameter int MAX_FRAME_LEN     = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    input  logic                         i_first,
    input  logic                         i_last,
    input  logic [TASK_INPUT_WIDTH-1:0]  i_data,
    input  logic [1:0]                   i_mode,
    output logic                         o_valid,
    output logic                         o_last,
    output logic [TASK_OUTPUT_WIDTH-1:0] o_data,
    output logic                         o_busy,
    output logic                         o_drop
);

    localparam int CW = $clog2(MAX_FRAME_LEN + 1);
    localparam int AW = (MAX_FRAME_LEN > 1) ? $clog2(MAX_FRAME_LEN) : 1;
    localparam int OW = TASK_OUTPUT_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_SUM   = 2'd3;

    localparam logic [CW-1:0] LEN_MAX = CW'(MAX_FRAME_LEN);
    localparam logic [CW-1:0] LEN_ONE = CW'(1);

    // Input word converted to output width: zero-extend or keep the LSBs.
    logic [OW-1:0] in_ext;
    if (OW >= TASK_INPUT_WIDTH) begin : g_widen
        assign in_ext = OW'(i_data);
    end else begin : g_narrow
        assign in_ext = i_data[OW-1:0];
    end

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] len_q, len_d;
    logic [OW-1:0] sum_q, sum_d;
    logic [1:0]    mode_q, mode_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;     // words read from the buffer
    logic [CW-1:0] out_cnt_q, out_cnt_d;   // words driven on the output
    logic          rd_vld_q, rd_vld_d;     // rd_data_q holds a word to emit
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic [OW-1:0] data_q, data_d;
    logic          drop_q, drop_d;

    logic          take_first;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [CW-1:0] rev_idx;

    logic [OW-1:0] mem [MAX_FRAME_LEN];
    logic [OW-1:0] rd_data_q;

    // Read address: forward walks 0..len-1, reverse walks len-1..0.
    assign rev_idx = len_q - LEN_ONE - rd_cnt_q;
    assign rd_addr = mode_q[0] ? rev_idx[AW-1:0] : rd_cnt_q[AW-1:0];

    always_comb begin
        // NOTE: every signal gets a default before the case, so that no path
        // leaves it unassigned. A path with no assignment would infer a latch.
        state_d    = state_q;
        len_d      = len_q;
        sum_d      = sum_q;
        mode_d     = mode_q;
        rd_cnt_d   = rd_cnt_q;
        out_cnt_d  = out_cnt_q;
        rd_vld_d   = 1'b0;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        data_d     = data_q;
        drop_d     = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = len_q[AW-1:0];
        take_first = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    if (i_first) take_first = 1'b1;
                    else         drop_d     = 1'b1;
                end
            end

            ST_FILL: begin
                if (i_valid) begin
                    if (i_first) begin
                        // Restart: the partial frame is abandoned.
                        drop_d     = 1'b1;
                        take_first = 1'b1;
                    end else if (len_q == LEN_MAX) begin
                        // Overflow: abort. The remainder of the frame drops in IDLE.
                        drop_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        wr_en = 1'b1;
                        len_d = len_q + LEN_ONE;
                        sum_d = sum_q + in_ext;
                        if (i_last) state_d = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                drop_d = i_valid;
                // Stage 1: issue the buffer read for the next word.
                if (rd_cnt_q != len_q) begin
                    rd_vld_d = 1'b1;
                    rd_cnt_d = rd_cnt_q + LEN_ONE;
                end
                // Stage 2: drive the word read on the previous cycle.
                if (rd_vld_q) begin
                    valid_d   = 1'b1;
                    data_d    = rd_data_q;
                    out_cnt_d = out_cnt_q + LEN_ONE;
                    if (out_cnt_q == len_q - LEN_ONE) begin
                        if (mode_q[1]) begin
                            state_d = ST_SUM;
                        end else begin
                            last_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end
            end

            ST_SUM: begin
                drop_d  = i_valid;
                valid_d = 1'b1;
                data_d  = sum_q;
                last_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase

        // A first word is treated the same way from IDLE and from FILL.
        if (take_first) begin
            wr_en     = 1'b1;
            wr_addr   = '0;
            len_d     = LEN_ONE;
            sum_d     = in_ext;
            mode_d    = i_mode;
            rd_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = i_last ? ST_DRAIN : ST_FILL;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then sees the values from before the edge, whatever order
    // the statements are written in.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            sum_q     <= '0;
            mode_q    <= '0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
            rd_vld_q  <= 1'b0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            sum_q     <= sum_d;
            mode_q    <= mode_d;
            rd_cnt_q  <= rd_cnt_d;
            out_cnt_q <= out_cnt_d;
            rd_vld_q  <= rd_vld_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            data_q    <= data_d;
            drop_q    <= drop_d;
        end
    end

    // NOTE: the buffer and its read register have no reset. Their contents
    // are qualified by len_q and rd_vld_q, so leaving out the reset keeps the
    // buffer mappable onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (wr_en)    mem[wr_addr] <= in_ext;
        if (rd_vld_d) rd_data_q    <= mem[rd_addr];
    end

    assign o_valid = valid_q;
    assign o_last  = last_q;
    assign o_data  = data_q;
    assign o_drop  = drop_q;
    assign o_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_task_frame_reorder.sv
// ---------------------------------------------------------------------------
// Testbench for task_frame_reorder, instantiated with MAX_FRAME_LEN = 4.
// Expected output words are queued when a frame is driven. A negedge monitor
// pops and compares them whenever o_valid is seen.
// ---------------------------------------------------------------------------
module tb_task_frame_reorder;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_first = 1'b0;
    logic        i_last = 1'b0;
    logic [15:0] i_data = '0;
    logic [1:0]  i_mode = '0;
    logic        o_valid, o_last, o_busy, o_drop;
    logic [15:0] o_data;

    task_frame_reorder #(
        .TASK_INPUT_WIDTH (16),
        .TASK_OUTPUT_WIDTH(16),
        .MAX_FRAME_LEN    (4)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_valid(i_valid),
        .i_first(i_first),
        .i_last (i_last),
        .i_data (i_data),
        .i_mode (i_mode),
        .o_valid(o_valid),
        .o_last (o_last),
        .o_data (o_data),
        .o_busy (o_busy),
        .o_drop (o_drop)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [1:0]       mode;
        logic [2:0]       n;     // input words
        logic [3:0][15:0] w;
        logic [2:0]       en;    // expected output words
        logic [4:0][15:0] e;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    int drops_seen = 0;
    int outs_seen = 0;
    int exp_drops = 0;
    logic [16:0] sb_q[$];   // {last, data}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] m, input int n,
                                input logic [15:0] w0, w1, w2, w3,
                                input int en,
                                input logic [15:0] e0, e1, e2, e3, e4);
        vec_t v;
        v.mode = m;
        v.n    = 3'(n);
        v.w    = {w3, w2, w1, w0};
        v.en   = 3'(en);
        v.e    = {e4, e3, e2, e1, e0};
        return v;
    endfunction

    // Drive one input word for one clock. Returns 1 time unit after the
    // sampling edge.
    task automatic send(input logic f, input logic l, input logic [15:0] d, input logic [1:0] m);
        i_valid = 1'b1;
        i_first = f;
        i_last  = l;
        i_data  = d;
        i_mode  = m;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_first = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic expect_word(input logic [15:0] d, input logic l);
        sb_q.push_back({l, d});
    endtask

    // Output monitor, sampling away from the active edge.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_drop) drops_seen++;
            if (o_valid) begin
                outs_seen++;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got %0h expected no output (t=%0t)", o_data, $time);
                end else begin
                    logic [16:0] exp_w;
                    exp_w = sb_q.pop_front();
                    check("o_data", 32'(o_data), 32'(exp_w[15:0]));
                    check("o_last", 32'(o_last), 32'(exp_w[16]));
                end
            end else begin
                check("o_last_idle", 32'(o_last), 32'd0);
            end
        end
    end

    vec_t vecs[7];

    initial begin
        int d0;
        int o0;

        vecs[0] = mk(2'd0, 3, 16'h0001, 16'h0002, 16'h0003, 16'h0, 3, 16'h0001, 16'h0002, 16'h0003, 16'h0, 16'h0);
        vecs[1] = mk(2'd3, 2, 16'hFFFF, 16'h0002, 16'h0, 16'h0, 3, 16'h0002, 16'hFFFF, 16'h0001, 16'h0, 16'h0);
        vecs[2] = mk(2'd1, 1, 16'h00AB, 16'h0, 16'h0, 16'h0, 1, 16'h00AB, 16'h0, 16'h0, 16'h0, 16'h0);
        vecs[3] = mk(2'd2, 4, 16'h1234, 16'h4321, 16'h0001, 16'h8000, 5, 16'h1234, 16'h4321, 16'h0001, 16'h8000, 16'hD556);
        vecs[4] = mk(2'd1, 4, 16'h000A, 16'h000B, 16'h000C, 16'h000D, 4, 16'h000D, 16'h000C, 16'h000B, 16'h000A, 16'h0);
        vecs[5] = mk(2'd2, 3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0, 4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFD, 16'h0);
        vecs[6] = mk(2'd0, 1, 16'h00CD, 16'h0, 16'h0, 16'h0, 1, 16'h00CD, 16'h0, 16'h0, 16'h0, 16'h0);

        // Reset state.
        #1;
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_last",  32'(o_last),  32'd0);
        check("rst_o_data",  32'(o_data),  32'd0);
        check("rst_o_busy",  32'(o_busy),  32'd0);
        check("rst_o_drop",  32'(o_drop),  32'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        cycles(1);

        // Table-driven frames: content, latency and busy timing.
        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            for (int j = 0; j < int'(v.en); j++)
                expect_word(v.e[j], j == int'(v.en) - 1);
            for (int k = 0; k < int'(v.n); k++)
                send(k == 0, k == int'(v.n) - 1, v.w[k], v.mode);
            // The last word was sampled at E0. Nothing appears at E0+1.
            cycles(1);
            check($sformatf("v%0d_lat_e1_valid", i), 32'(o_valid), 32'd0);
            cycles(1);
            check($sformatf("v%0d_lat_e2_valid", i), 32'(o_valid), 32'd1);
            check($sformatf("v%0d_busy_e2", i), 32'(o_busy),
                  32'((int'(v.n) > 1) || v.mode[1]));
            cycles(int'(v.en) + 2);
            check($sformatf("v%0d_drained", i), sb_q.size(), 32'd0);
            check($sformatf("v%0d_busy_end", i), 32'(o_busy), 32'd0);
        end
        check("table_no_drop", drops_seen, 32'(exp_drops));

        // Overflow: a 5-word frame with depth 4 is aborted on word 5.
        d0 = drops_seen;
        o0 = outs_seen;
        send(1'b1, 1'b0, 16'h0011, 2'd0);
        send(1'b0, 1'b0, 16'h0012, 2'd0);
        send(1'b0, 1'b0, 16'h0013, 2'd0);
        send(1'b0, 1'b0, 16'h0014, 2'd0);
        send(1'b0, 1'b1, 16'h0015, 2'd0);
        check("ovf_busy", 32'(o_busy), 32'd0);
        exp_drops++;
        cycles(6);
        check("ovf_drops", drops_seen - d0, 32'd1);
        check("ovf_no_output", outs_seen - o0, 32'd0);
        expect_word(16'h0005, 1'b0);
        expect_word(16'h0006, 1'b1);
        send(1'b1, 1'b0, 16'h0005, 2'd0);
        send(1'b0, 1'b1, 16'h0006, 2'd0);
        cycles(5);
        check("ovf_next_frame", sb_q.size(), 32'd0);

        // Input words during DRAIN are dropped. The replay is unchanged.
        d0 = drops_seen;
        expect_word(16'h0003, 1'b0);
        expect_word(16'h0002, 1'b0);
        expect_word(16'h0001, 1'b1);
        send(1'b1, 1'b0, 16'h0001, 2'd1);
        send(1'b0, 1'b0, 16'h0002, 2'd1);
        send(1'b0, 1'b1, 16'h0003, 2'd1);
        send(1'b1, 1'b0, 16'h0077, 2'd0);
        send(1'b0, 1'b0, 16'h0078, 2'd0);
        exp_drops += 2;
        cycles(5);
        check("drain_drops", drops_seen - d0, 32'd2);
        check("drain_replay", sb_q.size(), 32'd0);

        // A first word mid-FILL restarts the frame. The new mode is latched.
        d0 = drops_seen;
        expect_word(16'h000A, 1'b0);
        expect_word(16'h0009, 1'b1);
        send(1'b1, 1'b0, 16'h0007, 2'd0);
        send(1'b0, 1'b0, 16'h0008, 2'd0);
        send(1'b1, 1'b0, 16'h0009, 2'd1);
        send(1'b0, 1'b1, 16'h000A, 2'd1);
        exp_drops++;
        cycles(5);
        check("restart_drops", drops_seen - d0, 32'd1);
        check("restart_replay", sb_q.size(), 32'd0);

        // A stray word in IDLE is dropped. Back-to-back strays give one pulse each.
        d0 = drops_seen;
        send(1'b0, 1'b0, 16'h0055, 2'd0);
        send(1'b0, 1'b1, 16'h0056, 2'd0);
        exp_drops += 2;
        cycles(2);
        check("idle_drops", drops_seen - d0, 32'd2);
        check("idle_busy", 32'(o_busy), 32'd0);

        // Asynchronous reset in the middle of DRAIN.
        expect_word(16'h0001, 1'b0);
        expect_word(16'h0002, 1'b0);
        expect_word(16'h0003, 1'b0);
        expect_word(16'h0004, 1'b1);
        send(1'b1, 1'b0, 16'h0001, 2'd0);
        send(1'b0, 1'b0, 16'h0002, 2'd0);
        send(1'b0, 1'b0, 16'h0003, 2'd0);
        send(1'b0, 1'b1, 16'h0004, 2'd0);
        @(posedge i_clk);
        @(posedge i_clk);
        #3;
        check("pre_rst_valid", 32'(o_valid), 32'd1);
        i_rst = 1'b1;
        sb_q.delete();
        #1;
        check("arst_o_valid", 32'(o_valid), 32'd0);
        check("arst_o_last",  32'(o_last),  32'd0);
        check("arst_o_data",  32'(o_data),  32'd0);
        check("arst_o_busy",  32'(o_busy),  32'd0);
        check("arst_o_drop",  32'(o_drop),  32'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        o0 = outs_seen;
        cycles(10);
        check("post_rst_quiet", outs_seen - o0, 32'd0);
        expect_word(16'h0003, 1'b0);
        expect_word(16'h0004, 1'b0);
        expect_word(16'h0007, 1'b1);
        send(1'b1, 1'b0, 16'h0003, 2'd2);
        send(1'b0, 1'b1, 16'h0004, 2'd2);
        cycles(6);
        check("post_rst_frame", sb_q.size(), 32'd0);

        check("total_drops", drops_seen, 32'(exp_drops));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
